// File: rtl/mod_swapchain_if.sv
`default_nettype none
// ============================================================================
// Module      : mod_swapchain_if
// Description : Request/status bundle between the controller register file,
//               the segment-transition controller and the modulation reader.
//               Optional macro MOD_SWAPCHAIN_LOOP_CNT_EN adds loop_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
interface mod_swapchain_if #(
    parameter int REP_WIDTH  = 16,
    parameter int TIME_WIDTH = 64
);
    logic                  update_settings;
    logic                  req_rd_segment;
    logic [REP_WIDTH-1:0]  rep;
    logic [7:0]            transition_mode;
    logic [TIME_WIDTH-1:0] transition_value;
    logic [TIME_WIDTH-1:0] sys_time;
    logic [1:0]            idx_wrap;
    logic [3:0]            gpio_in;
    logic                  segment;
    logic                  stop;
    logic                  busy;
`ifdef MOD_SWAPCHAIN_LOOP_CNT_EN
    logic [REP_WIDTH-1:0]  loop_cnt;

    modport master (
        output update_settings, req_rd_segment, rep, transition_mode,
               transition_value, sys_time, idx_wrap, gpio_in,
        input  segment, stop, busy, loop_cnt
    );

    modport slave (
        input  update_settings, req_rd_segment, rep, transition_mode,
               transition_value, sys_time, idx_wrap, gpio_in,
        output segment, stop, busy, loop_cnt
    );
`else
    modport master (
        output update_settings, req_rd_segment, rep, transition_mode,
               transition_value, sys_time, idx_wrap, gpio_in,
        input  segment, stop, busy
    );

    modport slave (
        input  update_settings, req_rd_segment, rep, transition_mode,
               transition_value, sys_time, idx_wrap, gpio_in,
        output segment, stop, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/mod_swapchain.sv
`default_nettype none
// ============================================================================
// Module      : mod_swapchain
// Description : Segment-transition controller for the modulation path.
//               Decides when the reader switches to the requested segment
//               (sync index / system time / GPIO edge / external alternation),
//               counts finite repetitions and raises stop when exhausted.
//               Optional macro MOD_SWAPCHAIN_LOOP_CNT_EN exposes loop_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_swapchain #(
    parameter int REP_WIDTH  = 16,
    parameter int TIME_WIDTH = 64
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    mod_swapchain_if.slave bus
);

    localparam logic [7:0]           C_MODE_SYNC_IDX = 8'h00;
    localparam logic [7:0]           C_MODE_SYS_TIME = 8'h01;
    localparam logic [7:0]           C_MODE_GPIO     = 8'h02;
    localparam logic [7:0]           C_MODE_EXT      = 8'hF0;
    localparam logic [REP_WIDTH-1:0] C_REP_INF       = '1;

    typedef enum logic [2:0] {
        S_RUN_INF = 3'd0,
        S_WAIT    = 3'd1,
        S_RUN_FIN = 3'd2,
        S_STOPPED = 3'd3,
        S_RUN_EXT = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_segment;
    logic                  r_stop;
    logic                  r_busy;
    logic [REP_WIDTH-1:0]  r_cnt;
    logic [3:0]            r_gpio_d;
    logic                  r_req_seg;
    logic [REP_WIDTH-1:0]  r_req_rep;
    logic [7:0]            r_req_mode;
    logic [TIME_WIDTH-1:0] r_req_value;

    logic w_rep_inf;
    logic w_mode_ext;
    logic w_mode_known;
    logic w_accept;
    logic w_trig;

    // Classify the incoming request; unknown modes and finite EXT are dropped.
    always_comb begin
        w_rep_inf    = (bus.rep == C_REP_INF);
        w_mode_ext   = (bus.transition_mode == C_MODE_EXT);
        w_mode_known = (bus.transition_mode == C_MODE_SYNC_IDX) ||
                       (bus.transition_mode == C_MODE_SYS_TIME) ||
                       (bus.transition_mode == C_MODE_GPIO)     ||
                       w_mode_ext;
        w_accept     = bus.update_settings && w_mode_known &&
                       !(w_mode_ext && !w_rep_inf);
    end

    // Transition trigger for the latched request, evaluated while waiting.
    always_comb begin
        w_trig = 1'b0;
        case (r_req_mode)
            C_MODE_SYNC_IDX: w_trig = bus.idx_wrap[r_req_seg];
            C_MODE_SYS_TIME: w_trig = (bus.sys_time >= r_req_value);
            C_MODE_GPIO:     w_trig = bus.gpio_in[r_req_value[1:0]] &&
                                      !r_gpio_d[r_req_value[1:0]];
            default:         w_trig = 1'b0;
        endcase
    end

    // Main controller: request latching, wait/switch, loop counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN_INF;
            r_segment   <= 1'b0;
            r_stop      <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_gpio_d    <= 4'd0;
            r_req_seg   <= 1'b0;
            r_req_rep   <= '0;
            r_req_mode  <= 8'h00;
            r_req_value <= '0;
        end else begin
            r_gpio_d <= bus.gpio_in;
            if (bus.update_settings) begin
                // An update cycle masks wraps and triggers; a dropped
                // request leaves everything as it was.
                if (w_accept) begin
                    r_req_seg   <= bus.req_rd_segment;
                    r_req_rep   <= bus.rep;
                    r_req_mode  <= bus.transition_mode;
                    r_req_value <= bus.transition_value;
                    if (w_rep_inf) begin
                        r_segment <= bus.req_rd_segment;
                        r_stop    <= 1'b0;
                        r_busy    <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= w_mode_ext ? S_RUN_EXT : S_RUN_INF;
                    end else begin
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
            end else begin
                case (r_state)
                    S_WAIT: begin
                        if (w_trig) begin
                            r_segment <= r_req_seg;
                            r_busy    <= 1'b0;
                            r_stop    <= 1'b0;
                            r_cnt     <= '0;
                            r_state   <= S_RUN_FIN;
                        end
                    end
                    S_RUN_FIN: begin
                        if (bus.idx_wrap[r_segment]) begin
                            if (r_cnt == r_req_rep) begin
                                r_stop  <= 1'b1;
                                r_state <= S_STOPPED;
                            end else if (r_cnt != C_REP_INF) begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    S_RUN_EXT: begin
                        if (bus.idx_wrap[r_segment]) begin
                            r_segment <= ~r_segment;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.segment = r_segment;
    assign bus.stop    = r_stop;
    assign bus.busy    = r_busy;
`ifdef MOD_SWAPCHAIN_LOOP_CNT_EN
    assign bus.loop_cnt = r_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod_swapchain.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_swapchain
// Description : Directed self-checking bench for mod_swapchain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_swapchain;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mod_swapchain_if #(.REP_WIDTH(16), .TIME_WIDTH(64)) sif ();

    mod_swapchain #(.REP_WIDTH(16), .TIME_WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic seg, input logic [15:0] rep,
                       input logic [7:0] mode, input logic [63:0] val);
        sif.req_rd_segment   = seg;
        sif.rep              = rep;
        sif.transition_mode  = mode;
        sif.transition_value = val;
        sif.update_settings  = 1'b1;
        tick();
        sif.update_settings  = 1'b0;
    endtask

    task automatic wrap(input logic [1:0] w);
        sif.idx_wrap = w;
        tick();
        sif.idx_wrap = 2'b00;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        sif.update_settings  = 1'b0;
        sif.req_rd_segment   = 1'b0;
        sif.rep              = 16'd0;
        sif.transition_mode  = 8'h00;
        sif.transition_value = 64'd0;
        sif.sys_time         = 64'd0;
        sif.idx_wrap         = 2'b00;
        sif.gpio_in          = 4'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg",  sif.segment, 1'b0);
        chk("rst_busy", sif.busy,    1'b0);
        chk("rst_stop", sif.stop,    1'b0);
        rst_n = 1'b1;
        tick();

        // 1: infinite request switches one cycle later
        upd(1'b1, 16'hFFFF, 8'h00, 64'd0);
        chk("t1_seg",  sif.segment, 1'b1);
        chk("t1_busy", sif.busy,    1'b0);
        chk("t1_stop", sif.stop,    1'b0);

        // 2: SYNC_IDX, REP=2 -> three loops then stop
        upd(1'b1, 16'd2, 8'h00, 64'd0);
        chk("t2_wait_busy", sif.busy, 1'b1);
        wrap(2'b01);
        chk("t2_wrong_wrap_busy", sif.busy, 1'b1);
        wrap(2'b10);
        chk("t2_sw_busy", sif.busy,    1'b0);
        chk("t2_sw_seg",  sif.segment, 1'b1);
        chk("t2_sw_stop", sif.stop,    1'b0);
        for (int i = 1; i <= 3; i++) begin
            wrap(2'b10);
            chk("t2_loop_stop", sif.stop, (i == 3));
            tick();
            chk("t2_idle_stop", sif.stop, (i == 3));
        end
        chk("t2_hold_seg", sif.segment, 1'b1);

        // 3: SYS_TIME target 1000, REP=0
        sif.sys_time = 64'd990;
        upd(1'b0, 16'd0, 8'h01, 64'd1000);
        chk("t3_wait_busy", sif.busy,    1'b1);
        chk("t3_wait_seg",  sif.segment, 1'b1);
        for (int t = 991; t <= 1000; t++) begin
            sif.sys_time = 64'(t);
            tick();
            chk("t3_ramp_busy", sif.busy,    (t < 1000));
            chk("t3_ramp_seg",  sif.segment, (t < 1000));
        end
        chk("t3_sw_stop", sif.stop, 1'b0);
        sif.sys_time = 64'd1005;
        wrap(2'b01);
        chk("t3_fin_stop", sif.stop,    1'b1);
        chk("t3_fin_seg",  sif.segment, 1'b0);

        // 4: GPIO bit 2, already high at request -> needs a fresh rising edge
        sif.gpio_in = 4'b0100;
        tick();
        upd(1'b1, 16'd0, 8'h02, 64'd2);
        chk("t4_wait_busy", sif.busy, 1'b1);
        tick();
        chk("t4_high_busy", sif.busy,    1'b1);
        chk("t4_high_seg",  sif.segment, 1'b0);
        sif.gpio_in = 4'b0000;
        tick();
        chk("t4_low_busy", sif.busy, 1'b1);
        sif.gpio_in = 4'b0100;
        tick();
        chk("t4_sw_seg",  sif.segment, 1'b1);
        chk("t4_sw_busy", sif.busy,    1'b0);
        chk("t4_sw_stop", sif.stop,    1'b0);

        // 5: EXT alternation; unknown mode and finite EXT dropped
        upd(1'b0, 16'hFFFF, 8'hF0, 64'd0);
        chk("t5_seg0",  sif.segment, 1'b0);
        chk("t5_busy",  sif.busy,    1'b0);
        wrap(2'b01);
        chk("t5_tog1", sif.segment, 1'b1);
        wrap(2'b01);
        chk("t5_other_wrap", sif.segment, 1'b1);
        wrap(2'b10);
        chk("t5_tog0", sif.segment, 1'b0);
        upd(1'b1, 16'hFFFF, 8'hAA, 64'd0);
        chk("t5_bad_mode_seg",  sif.segment, 1'b0);
        chk("t5_bad_mode_busy", sif.busy,    1'b0);
        wrap(2'b01);
        chk("t5_still_ext", sif.segment, 1'b1);
        upd(1'b0, 16'd3, 8'hF0, 64'd0);
        chk("t5_fin_ext_seg",  sif.segment, 1'b1);
        chk("t5_fin_ext_busy", sif.busy,    1'b0);
        wrap(2'b10);
        chk("t5_ext_after_drop", sif.segment, 1'b0);
        wrap(2'b01);
        chk("t5_tog_again", sif.segment, 1'b1);

        // 6: async reset mid-wait, then re-request while waiting
        sif.gpio_in = 4'b0000;
        upd(1'b0, 16'd1, 8'h00, 64'd0);
        chk("t6_wait_busy", sif.busy,    1'b1);
        chk("t6_wait_seg",  sif.segment, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_seg",  sif.segment, 1'b0);
        chk("t6_async_busy", sif.busy,    1'b0);
        chk("t6_async_stop", sif.stop,    1'b0);
        tick();
        rst_n = 1'b1;
        wrap(2'b01);
        chk("t6_discard_busy", sif.busy,    1'b0);
        chk("t6_discard_seg",  sif.segment, 1'b0);
        upd(1'b1, 16'd0, 8'h00, 64'd0);
        chk("t6_req1_busy", sif.busy, 1'b1);
        upd(1'b0, 16'd0, 8'h02, 64'd3);
        chk("t6_req2_busy", sif.busy, 1'b1);
        wrap(2'b10);
        chk("t6_old_trig_busy", sif.busy,    1'b1);
        chk("t6_old_trig_seg",  sif.segment, 1'b0);
        sif.gpio_in = 4'b1000;
        tick();
        chk("t6_new_trig_busy", sif.busy,    1'b0);
        chk("t6_new_trig_seg",  sif.segment, 1'b0);

        // Update cycle masks a simultaneous wrap: REP=0 stops only on a later wrap
        wrap(2'b01);
        chk("t7_stop_after_wrap", sif.stop, 1'b1);
        sif.idx_wrap = 2'b10;
        upd(1'b1, 16'd0, 8'h00, 64'd0);
        sif.idx_wrap = 2'b00;
        chk("t7_masked_busy", sif.busy, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
